// File: rtl/xu_fctr_mt_pkg.sv
// Shared constants for the XU multi-thread flush/stall delay counter.
// The thread-count default lives here so integrations size every XU counter the same way.
package xu_fctr_mt_pkg;
   localparam int XU_THREADS     = 2;
   localparam int XU_DELAY_WIDTH = 4;
endpackage

// File: rtl/xu_fctr_chan.sv
// One counter channel: holds the stretch counter and expiry flag for a single thread.
// It resolves cancel/set/hold/decrement priority and produces the stretched request.
module xu_fctr_chan #(
   parameter int DELAY_WIDTH = 4,
   parameter bit PASSTHRU    = 1'b1,
   parameter bit RETRIGGER   = 1'b1
) (
   input  logic                   nclk,
   input  logic                   sreset,
   input  logic                   din,
   input  logic [DELAY_WIDTH-1:0] delay,
   input  logic                   cancel,
   input  logic                   hold,
   output logic                   dout,
   output logic                   done,
   output logic                   active
);
   localparam logic [DELAY_WIDTH-1:0] ONE = DELAY_WIDTH'(1);

   logic [DELAY_WIDTH-1:0] cnt;
   logic [DELAY_WIDTH-1:0] cnt_nxt;
   logic                   done_q;
   logic                   done_nxt;
   logic                   set_ok;

   always_comb begin
      active   = (cnt != '0);
      // Without retrigger a set is only taken by an idle channel.
      set_ok   = din && (RETRIGGER || !active);
      cnt_nxt  = cnt;
      done_nxt = 1'b0;
      if (cancel) begin
         cnt_nxt = '0;
      end else if (set_ok) begin
         cnt_nxt = delay;
      end else if (hold) begin
         cnt_nxt = cnt;
      end else if (active) begin
         cnt_nxt  = cnt - ONE;
         done_nxt = (cnt == ONE);
      end else begin
         cnt_nxt = '0;
      end
   end

   always_ff @(posedge nclk) begin
      if (sreset) begin
         cnt    <= '0;
         done_q <= 1'b0;
      end else begin
         cnt    <= cnt_nxt;
         done_q <= done_nxt;
      end
   end

   assign dout = active | (PASSTHRU & din & ~cancel);
   assign done = done_q;
endmodule

// File: rtl/xu_fctr_mt.sv
// Multi-thread flush/stall delay counter: one independent stretch channel per thread,
// with a registered-state summary of whether any channel is still counting.
module xu_fctr_mt
   import xu_fctr_mt_pkg::*;
#(
   parameter int THREADS     = XU_THREADS,
   parameter int DELAY_WIDTH = XU_DELAY_WIDTH,
   parameter bit PASSTHRU    = 1'b1,
   parameter bit RETRIGGER   = 1'b1
) (
   input  logic                           nclk,
   input  logic                           sreset,
   input  logic [THREADS-1:0]             din,
   input  logic [THREADS*DELAY_WIDTH-1:0] delay,
   input  logic [THREADS-1:0]             cancel,
   input  logic                           hold,
   output logic [THREADS-1:0]             dout,
   output logic [THREADS-1:0]             done,
   output logic                           any_active
);
   logic [THREADS-1:0] active;

   for (genvar t = 0; t < THREADS; t++) begin : g_chan
      xu_fctr_chan #(
         .DELAY_WIDTH (DELAY_WIDTH),
         .PASSTHRU    (PASSTHRU),
         .RETRIGGER   (RETRIGGER)
      ) u_chan (
         .nclk   (nclk),
         .sreset (sreset),
         .din    (din[t]),
         .delay  (delay[t*DELAY_WIDTH +: DELAY_WIDTH]),
         .cancel (cancel[t]),
         .hold   (hold),
         .dout   (dout[t]),
         .done   (done[t]),
         .active (active[t])
      );
   end

   // Built from counter state only, so a passthru request never shows up here.
   assign any_active = |active;
endmodule

// File: tb/tb_xu_fctr_mt.sv
// Directed bench for xu_fctr_mt: two instances share stimulus, one with passthru+retrigger,
// the other with neither, and every cycle's outputs are checked against hand-derived values.
module tb_xu_fctr_mt;
   logic       nclk;
   logic       sreset;
   logic [1:0] din;
   logic [7:0] delay;
   logic [1:0] cancel;
   logic       hold;
   logic [1:0] dout_a, done_a, dout_b, done_b;
   logic       any_a, any_b;
   int         tests;
   int         failed;
   int         step;

   xu_fctr_mt #(.THREADS(2), .DELAY_WIDTH(4), .PASSTHRU(1'b1), .RETRIGGER(1'b1)) dut_a (
      .nclk(nclk), .sreset(sreset), .din(din), .delay(delay), .cancel(cancel), .hold(hold),
      .dout(dout_a), .done(done_a), .any_active(any_a));

   xu_fctr_mt #(.THREADS(2), .DELAY_WIDTH(4), .PASSTHRU(1'b0), .RETRIGGER(1'b0)) dut_b (
      .nclk(nclk), .sreset(sreset), .din(din), .delay(delay), .cancel(cancel), .hold(hold),
      .dout(dout_b), .done(done_b), .any_active(any_b));

   initial begin
      nclk = 1'b0;
      forever #5 nclk = ~nclk;
   end

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s step %0d: observed %b expected %b", tag, step, obs, exp);
      end
   endtask

   // Drive one cycle's inputs, check that cycle's outputs, then advance past the edge.
   task automatic cyc(input logic r, input logic [1:0] di, input logic [3:0] dl1,
                      input logic [3:0] dl0, input logic [1:0] cn, input logic hd,
                      input logic [1:0] e_dout_a, input logic [1:0] e_done_a, input logic e_any_a,
                      input logic [1:0] e_dout_b, input logic [1:0] e_done_b, input logic e_any_b);
      sreset = r;
      din    = di;
      delay  = {dl1, dl0};
      cancel = cn;
      hold   = hd;
      #1;
      chk("dout_a", dout_a, e_dout_a);
      chk("done_a", done_a, e_done_a);
      chk("any_a", {1'b0, any_a}, {1'b0, e_any_a});
      chk("dout_b", dout_b, e_dout_b);
      chk("done_b", done_b, e_done_b);
      chk("any_b", {1'b0, any_b}, {1'b0, e_any_b});
      step++;
      @(posedge nclk);
      #1;
   endtask

   initial begin
      tests = 0; failed = 0; step = 0;
      sreset = 1'b1; din = '0; delay = '0; cancel = '0; hold = 1'b0;
      repeat (2) @(posedge nclk);
      #1;
      //   rst din  d1 d0 can hld | doutA doneA anyA | doutB doneB anyB
      // reset state, then passthru visible while in reset
      cyc(1, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
      cyc(1, 2'b01, 0, 3, 2'b00, 0, 2'b01, 2'b00, 0, 2'b00, 2'b00, 0);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0);

      // basic stretch, delay 3 on thread 0
      cyc(0, 2'b01, 0, 3, 2'b00, 0, 2'b01, 2'b00, 0, 2'b00, 2'b00, 0);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b01, 2'b00, 1, 2'b01, 2'b00, 1);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b01, 2'b00, 1, 2'b01, 2'b00, 1);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b01, 2'b00, 1, 2'b01, 2'b00, 1);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b01, 0, 2'b00, 2'b01, 0);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0);

      // set delay 5, second set delay 2 three cycles later
      cyc(0, 2'b01, 0, 5, 2'b00, 0, 2'b01, 2'b00, 0, 2'b00, 2'b00, 0);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b01, 2'b00, 1, 2'b01, 2'b00, 1);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b01, 2'b00, 1, 2'b01, 2'b00, 1);
      cyc(0, 2'b01, 0, 2, 2'b00, 0, 2'b01, 2'b00, 1, 2'b01, 2'b00, 1);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b01, 2'b00, 1, 2'b01, 2'b00, 1);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b01, 2'b00, 1, 2'b01, 2'b00, 1);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b01, 0, 2'b00, 2'b01, 0);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0);

      // retrigger in the expiry cycle: A reloads and skips done, B ignores and expires
      cyc(0, 2'b01, 0, 2, 2'b00, 0, 2'b01, 2'b00, 0, 2'b00, 2'b00, 0);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b01, 2'b00, 1, 2'b01, 2'b00, 1);
      cyc(0, 2'b01, 0, 3, 2'b00, 0, 2'b01, 2'b00, 1, 2'b01, 2'b00, 1);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b01, 2'b00, 1, 2'b00, 2'b01, 0);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b01, 2'b00, 1, 2'b00, 2'b00, 0);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b01, 2'b00, 1, 2'b00, 2'b00, 0);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b01, 0, 2'b00, 2'b00, 0);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0);

      // delay 4 with hold in relative cycles 2-3
      cyc(0, 2'b01, 0, 4, 2'b00, 0, 2'b01, 2'b00, 0, 2'b00, 2'b00, 0);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b01, 2'b00, 1, 2'b01, 2'b00, 1);
      cyc(0, 2'b00, 0, 0, 2'b00, 1, 2'b01, 2'b00, 1, 2'b01, 2'b00, 1);
      cyc(0, 2'b00, 0, 0, 2'b00, 1, 2'b01, 2'b00, 1, 2'b01, 2'b00, 1);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b01, 2'b00, 1, 2'b01, 2'b00, 1);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b01, 2'b00, 1, 2'b01, 2'b00, 1);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b01, 2'b00, 1, 2'b01, 2'b00, 1);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b01, 0, 2'b00, 2'b01, 0);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0);

      // set under hold still loads
      cyc(0, 2'b01, 0, 2, 2'b00, 1, 2'b01, 2'b00, 0, 2'b00, 2'b00, 0);
      cyc(0, 2'b00, 0, 0, 2'b00, 1, 2'b01, 2'b00, 1, 2'b01, 2'b00, 1);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b01, 2'b00, 1, 2'b01, 2'b00, 1);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b01, 2'b00, 1, 2'b01, 2'b00, 1);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b01, 0, 2'b00, 2'b01, 0);

      // delay 4 cancelled in relative cycle 2
      cyc(0, 2'b01, 0, 4, 2'b00, 0, 2'b01, 2'b00, 0, 2'b00, 2'b00, 0);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b01, 2'b00, 1, 2'b01, 2'b00, 1);
      cyc(0, 2'b00, 0, 0, 2'b01, 0, 2'b01, 2'b00, 1, 2'b01, 2'b00, 1);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0);

      // reset mid-count aborts with no done
      cyc(0, 2'b01, 0, 2, 2'b00, 0, 2'b01, 2'b00, 0, 2'b00, 2'b00, 0);
      cyc(1, 2'b00, 0, 0, 2'b00, 0, 2'b01, 2'b00, 1, 2'b01, 2'b00, 1);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0);

      // delay 0: passthru only
      cyc(0, 2'b01, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0, 2'b00, 2'b00, 0);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0);

      // both threads, delays 1 and 7, thread 1 cancelled at its last count
      cyc(0, 2'b11, 7, 1, 2'b00, 0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 0);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b11, 2'b00, 1, 2'b11, 2'b00, 1);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b10, 2'b01, 1, 2'b10, 2'b01, 1);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b10, 2'b00, 1, 2'b10, 2'b00, 1);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b10, 2'b00, 1, 2'b10, 2'b00, 1);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b10, 2'b00, 1, 2'b10, 2'b00, 1);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b10, 2'b00, 1, 2'b10, 2'b00, 1);
      cyc(0, 2'b00, 0, 0, 2'b10, 0, 2'b10, 2'b00, 1, 2'b10, 2'b00, 1);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/xu_fctr_mt.md
Name: xu_fctr_mt

Overview:
- Multi-thread configurable flush/stall delay counter for XU completion logic.
- Next generation of the per-thread flush delay counter, with:
  - per-thread delay values
  - selectable retrigger / no-retrigger mode
  - per-thread cancel
  - global hold (freeze)
  - one-cycle expiry pulse and an any-active summary
- Sits between the flush/stall request sources and the consumers that must see the request stretched by a programmable number of cycles.

Parameters:
- THREADS, 2, number of independent counter channels.
- DELAY_WIDTH, 4, width of each counter and each delay value (max delay 2^DELAY_WIDTH-1).
- PASSTHRU, 1, 1 = dout includes same-cycle din; 0 = dout reflects counter state only.
- RETRIGGER, 1, 1 = set while counting reloads the counter; 0 = set while counting is ignored.

Ports:
- nclk  in  1  clock; all state on rising edge.
- sreset  in  1  synchronous active-high reset.
- din  in  THREADS  per-thread start request (set).
- delay  in  THREADS*DELAY_WIDTH  per-thread load value; thread t uses bits [t*DELAY_WIDTH +: DELAY_WIDTH].
- cancel  in  THREADS  per-thread abort; clears counter.
- hold  in  1  global freeze of decrement.
- dout  out  THREADS  stretched request.
- done  out  THREADS  registered one-cycle expiry pulse.
- any_active  out  1  OR of all counters non-zero (registered-state based).

Behaviour:
- Interface decision: one clock, nclk; reset sreset is synchronous and active-high.
- State per thread: cnt[t] (DELAY_WIDTH bits) and done_q[t]; active[t] = (cnt[t] != 0).
- Reset: every cnt and done_q goes to 0.
  - dout = 0 if PASSTHRU=0, else din & ~cancel.
  - done = 0, any_active = 0.
  - A reset asserted mid-count aborts all channels with no done pulse.
- Next-state priority per thread, highest first:
  1. sreset → cnt = 0.
  2. cancel[t] → cnt = 0.
  3. Accepted set → cnt = delay[t].
     - Accepted when din[t]=1 and (RETRIGGER=1 or cnt[t]=0).
  4. hold=1 → cnt unchanged.
  5. active[t] → cnt = cnt - 1.
  6. Otherwise cnt stays 0.
- Counters never wrap: the decrement applies only when cnt != 0.
- Accepted set overrides hold: a load happens even while frozen.
- Load of delay=0 leaves cnt at 0, so there is no stretch; dout is high only via PASSTHRU.
- done_q[t] next = 1 only when cnt[t]=1 and decrement taken (no sreset, cancel, accepted set or hold); else 0.
  - A cancel or retrigger in the expiry cycle suppresses done.
- dout[t] = active[t] | (PASSTHRU & din[t] & ~cancel[t]); combinational from state and inputs.
- any_active = OR over active[t]; excludes passthru.
- Timing for a set accepted in cycle n with delay D>0, no hold/cancel:
  - cnt = D in cycle n+1, decrementing to 1 in cycle n+D and 0 in cycle n+D+1.
  - dout high cycles n+1..n+D, plus cycle n when PASSTHRU=1.
  - done high in cycle n+D+1 only.
- hold for k cycles during a count extends dout and delays done by exactly k cycles.
- RETRIGGER=0: a set ignored while counting has no effect on cnt.
  - dout is already high, so its passthru contribution is invisible.
- Channels are fully independent; simultaneous events on different threads do not interact.

Decomposition:
- No shared package types are needed; use the codebase's existing thread-count define as the THREADS default source where it is integrated.
- One sub-module is natural: xu_fctr_chan, a single channel holding cnt, done_q, priority logic and dout.
  - The top instantiates THREADS copies and ORs their active outputs.

Test Plan:
- PASSTHRU=1, RETRIGGER=1, thread0 din pulse cycle 10 with delay=3 → dout0 high cycles 10-13, done0 pulse cycle 14, any_active high 11-13, thread1 quiet.
- RETRIGGER=1, set delay=5 at cycle 0, set again delay=2 at cycle 3 → cnt reloads to 2 at cycle 4, dout high through cycle 5, single done pulse at cycle 6. Same stimulus with RETRIGGER=0 → second set ignored, done at cycle 6 from the first count (cnt 5..1 over cycles 1-5).
- Set delay=4 at cycle 0, hold high cycles 2-3 → cnt stays 3 for cycles 2-4, dout high through cycle 6, done at cycle 7.
- Set delay=4 at cycle 0, cancel at cycle 2 → cnt 0 at cycle 3, dout low from cycle 3 (cycle 2 dout high via state only), no done pulse.
- Set delay=2 at cycle 0, sreset at cycle 1 → all cnt 0 at cycle 2, no done; delay=0 set → dout high only in the set cycle with PASSTHRU=1, never with PASSTHRU=0, no done.
- Both threads set same cycle, delays 1 and 7, cancel thread1 at its cnt=1 cycle → done0 only at cycle 2; done1 never; any_active low from cycle 8.
